// File: rtl/elevator_pkg.sv
// Shared encodings for the single-car elevator scheduler: car command opcodes and FSM states.
package elevator_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_SERVE = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/elevator_req_latch.sv
// Pending-request register: active-low press inputs set bits, a strobed index clears one bit.
module elevator_req_latch #(
    parameter int N     = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     set_n_a,
    input  logic [N-1:0]     set_n_b,
    input  logic [WIDTH-1:0] clr_idx,
    input  logic             clr,
    output logic [N-1:0]     request
);

    logic [N-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (clr && (clr_idx == WIDTH'(i))) begin
                clr_mask[i] = 1'b1;
            end
        end
    end

    // Clear wins over a press in the same cycle; a held button re-sets on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request <= '0;
        end else begin
            request <= (request | ~set_n_a | ~set_n_b) & ~clr_mask;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for one elevator car: latches calls, issues UP/DOWN/SERVE commands, watchdogs the car.
//   state    | meaning
//   ST_IDLE  | no command outstanding; pick next action when a request is pending
//   ST_ISSUE | cmd_valid high, holding cmd_op until the car asserts cmd_ready
//   ST_WAIT  | command accepted; waiting for cmd_done, watchdog running
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 2,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     button_out,
    input  logic [N-1:0]     button_in,
    input  logic [WIDTH-1:0] car_floor,
    input  logic             cmd_ready,
    input  logic             cmd_done,
    output logic             cmd_valid,
    output logic [1:0]       cmd_op,
    output logic [N-1:0]     request,
    output logic             dir_up,
    output logic             fault
);

    localparam logic [WIDTH:0] N_LIM   = (WIDTH+1)'(N);
    localparam logic [TW-1:0]  WD_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    logic [WIDTH-1:0] served_floor;
    logic             served_is_serve;
    logic [TW-1:0]    wd_cnt;
    logic [N-1:0]     here_mask;
    logic [N-1:0]     above_mask;
    logic [N-1:0]     below_mask;
    logic             floor_ok;
    logic             any_here;
    logic             any_above;
    logic             any_below;
    logic             clr_req;

    assign floor_ok = ({1'b0, car_floor} < N_LIM);

    always_comb begin
        here_mask  = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < N; i++) begin
            here_mask[i]  = (WIDTH'(i) == car_floor);
            above_mask[i] = (WIDTH'(i) >  car_floor);
            below_mask[i] = (WIDTH'(i) <  car_floor);
        end
    end

    assign any_here  = |(request & here_mask);
    assign any_above = |(request & above_mask);
    assign any_below = |(request & below_mask);
    assign clr_req   = (state == ST_WAIT) && cmd_done && served_is_serve;

    elevator_req_latch #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_req_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_n_a (button_out),
        .set_n_b (button_in),
        .clr_idx (served_floor),
        .clr     (clr_req),
        .request (request)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cmd_valid       <= 1'b0;
            cmd_op          <= OP_NONE;
            dir_up          <= 1'b1;
            fault           <= 1'b0;
            wd_cnt          <= '0;
            served_floor    <= '0;
            served_is_serve <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((request != '0) && floor_ok) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        if (any_here) begin
                            cmd_op <= OP_SERVE;
                        end else if (dir_up && any_above) begin
                            cmd_op <= OP_UP;
                        end else if (!dir_up && any_below) begin
                            cmd_op <= OP_DOWN;
                        end else if (any_above) begin
                            cmd_op <= OP_UP;
                            dir_up <= 1'b1;
                        end else begin
                            cmd_op <= OP_DOWN;
                            dir_up <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state           <= ST_WAIT;
                        cmd_valid       <= 1'b0;
                        cmd_op          <= OP_NONE;
                        served_floor    <= car_floor;
                        served_is_serve <= (cmd_op == OP_SERVE);
                        wd_cnt          <= '0;
                    end
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still counts as a clean finish.
                    if (cmd_done) begin
                        state <= ST_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        fault <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: vector table, hand sequences for multi-cycle corners, random vs. model.
module tb_elevator_scheduler;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bo = 4'hF, bi = 4'hF;
    logic [1:0] cf = 2'd0;
    logic       rdy = 1'b0, done = 1'b0;
    logic       valid, dir, flt;
    logic [1:0] op;
    logic [3:0] req;

    logic [2:0] bo3 = 3'h7, bi3 = 3'h7;
    logic [1:0] cf3 = 2'd0;
    logic       rdy3 = 1'b0, done3 = 1'b0;
    logic       valid3, dir3, flt3;
    logic [1:0] op3;
    logic [2:0] req3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(.N(4), .WIDTH(2), .TIMEOUT(TIMEOUT), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n), .button_out(bo), .button_in(bi), .car_floor(cf),
        .cmd_ready(rdy), .cmd_done(done), .cmd_valid(valid), .cmd_op(op),
        .request(req), .dir_up(dir), .fault(flt));

    elevator_scheduler #(.N(3), .WIDTH(2), .TIMEOUT(TIMEOUT), .TW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .button_out(bo3), .button_in(bi3), .car_floor(cf3),
        .cmd_ready(rdy3), .cmd_done(done3), .cmd_valid(valid3), .cmd_op(op3),
        .request(req3), .dir_up(dir3), .fault(flt3));

    // Reference model: pending set, phase (0 idle, 1 offering, 2 car busy), SCAN direction.
    bit [3:0] m_req;
    int       m_phase;
    bit [1:0] m_op;
    bit       m_dir, m_fault, m_serve;
    int       m_wait, m_floor;

    function automatic logic [2:0] decide(logic [3:0] r, int f, logic d);
        bit above, below;
        above = 0;
        below = 0;
        for (int j = 0; j < N; j++) begin
            if (r[j] && j > f) above = 1;
            if (r[j] && j < f) below = 1;
        end
        if (r[f]) return {d, 2'b11};
        if (d ? above : !below) return {1'b1, 2'b01};
        return {1'b0, 2'b10};
    endfunction

    task automatic model_reset();
        m_req = 0; m_phase = 0; m_op = 0; m_dir = 1; m_fault = 0;
        m_serve = 0; m_wait = 0; m_floor = 0;
    endtask

    task automatic model_edge();
        bit [3:0] nreq;
        nreq = m_req | ~bo | ~bi;
        case (m_phase)
            0: if (m_req != 0 && int'(cf) < N) begin
                {m_dir, m_op} = decide(m_req, int'(cf), m_dir);
                m_phase = 1;
            end
            1: if (rdy) begin
                m_phase = 2; m_floor = int'(cf); m_serve = (m_op == 2'b11); m_wait = 0;
            end
            default: if (done) begin
                if (m_serve) nreq[m_floor] = 0;
                m_phase = 0;
            end else begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin m_fault = 1; m_phase = 0; end
            end
        endcase
        m_req = nreq;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bo = 4'hF; bi = 4'hF; rdy = 0; done = 0;
        bo3 = 3'h7; bi3 = 3'h7; rdy3 = 0; done3 = 0;
    endtask

    // Asserted between clock edges so the asynchronous path is what gets observed.
    task automatic reset_check(string tag);
        #1 rst_n = 0;
        model_reset();
        idle_inputs();
        #1;
        check({tag, " reset outputs"}, {valid, op, req, dir, flt}, {1'b0, 2'b00, 4'h0, 1'b1, 1'b0});
        #4 rst_n = 1;
    endtask

    typedef struct {
        logic [3:0] bo, bi;
        logic [1:0] cf;
        logic       rdy, done;
        logic       ev;
        logic [1:0] eop;
        logic [3:0] ereq;
        logic       edir;
    } vec_t;

    vec_t vecs[$];

    initial begin
        model_reset();
        #7 rst_n = 1;

        // Floor-1 hall call from floor 0, then floors 0 and 3 called from floor 2.
        vecs.push_back('{4'b1101, 4'hF, 2'd0, 0, 0, 0, 2'b00, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd0, 0, 0, 1, 2'b01, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd0, 1, 0, 0, 2'b00, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd1, 0, 1, 0, 2'b00, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd1, 0, 0, 1, 2'b11, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd1, 1, 0, 0, 2'b00, 4'b0010, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd1, 0, 1, 0, 2'b00, 4'b0000, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd1, 0, 0, 0, 2'b00, 4'b0000, 1});
        vecs.push_back('{4'b0110, 4'hF, 2'd2, 0, 0, 0, 2'b00, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd2, 0, 0, 1, 2'b01, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd2, 1, 0, 0, 2'b00, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 0, 1, 0, 2'b00, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 0, 0, 1, 2'b11, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 1, 0, 0, 2'b00, 4'b1001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 0, 1, 0, 2'b00, 4'b0001, 1});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 0, 0, 1, 2'b10, 4'b0001, 0});
        vecs.push_back('{4'hF,    4'hF, 2'd3, 1, 0, 0, 2'b00, 4'b0001, 0});

        @(posedge clk); #1;
        check("post-reset", {valid, op, req, dir, flt}, {1'b0, 2'b00, 4'h0, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            bo = vecs[i].bo; bi = vecs[i].bi; cf = vecs[i].cf;
            rdy = vecs[i].rdy; done = vecs[i].done;
            tick();
            check($sformatf("row%0d valid", i), valid, vecs[i].ev);
            check($sformatf("row%0d op", i), op, vecs[i].eop);
            check($sformatf("row%0d request", i), req, vecs[i].ereq);
            check($sformatf("row%0d dir", i), dir, vecs[i].edir);
        end

        // Car is in WAIT with dir_up=0 here.
        reset_check("midwait");

        // Press at current floor alongside a call above; button held through the clearing edge.
        cf = 1; bi = 4'b1001;
        tick(); check("t4 latch", {valid, req}, {1'b0, 4'b0110});
        bi = 4'b1101;
        tick(); check("t4 serve first", {valid, op}, {1'b1, 2'b11});
        rdy = 1;
        tick(); check("t4 accept", valid, 1'b0);
        rdy = 0; done = 1;
        tick(); check("t4 clear beats set", {valid, req}, {1'b0, 4'b0100});
        done = 0;
        tick(); check("t4 re-set and up", {valid, op, req}, {1'b1, 2'b01, 4'b0110});
        reset_check("t4");

        // Long ready stall, then a car that never finishes.
        cf = 0; bo = 4'b0111;
        tick(); check("t5 latch", {valid, req}, {1'b0, 4'b1000});
        bo = 4'hF;
        tick(); check("t5 offer", {valid, op}, {1'b1, 2'b01});
        for (int k = 0; k < 20; k++) begin
            done = (k == 5);
            tick();
            check($sformatf("t5 stall%0d", k), {valid, op, flt}, {1'b1, 2'b01, 1'b0});
        end
        done = 0; rdy = 1;
        tick(); check("t5 accept", valid, 1'b0);
        rdy = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check($sformatf("t5 wait%0d", k), {valid, flt}, {1'b0, 1'b0});
        end
        tick(); check("t5 timeout", {valid, flt, req}, {1'b0, 1'b1, 4'b1000});
        tick(); check("t5 reissue under fault", {valid, op, flt}, {1'b1, 2'b01, 1'b1});
        reset_check("t5 fault clear");

        // Floor index 3: valid on the 4-floor car, out of range on the 3-floor car.
        cf = 3; bo = 4'b1110; cf3 = 3; bo3 = 3'b110;
        tick();
        check("t6 req4", req, 4'b0001);
        check("t6 req3", req3, 3'b001);
        bo = 4'hF; bo3 = 3'h7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6 n3 no issue%0d", k), {valid3, op3}, {1'b0, 2'b00});
        end
        check("t6 n4 issue", {valid, op, dir}, {1'b1, 2'b10, 1'b0});
        cf3 = 2;
        tick(); check("t6 n3 in range", {valid3, op3}, {1'b1, 2'b10});
        reset_check("t6");

        // Random car behaviour against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) reset_check("rand");
            bo = 4'hF; bi = 4'hF;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) bo[b] = 0;
                if ($urandom_range(0, 7) == 0) bi[b] = 0;
            end
            if ($urandom_range(0, 5) == 0) cf = 2'($urandom_range(0, 3));
            rdy  = ($urandom_range(0, 1) == 1);
            done = ($urandom_range(0, 5) == 0);
            tick();
            check($sformatf("rand%0d", c), {valid, op, req, dir, flt},
                  {(m_phase == 1), (m_phase == 1) ? m_op : 2'b00, m_req, m_dir, m_fault});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
